playback_sequencer: RTL
=======================

// Module: playback_sequencer
// PURPOSE
//  Sequences flash reads for audio playback. Turns codec sample requests into
//  two-byte flash fetches and assembles 16-bit samples for the audio interface.
//  Owns song selection (next/prev/restart) and playback rate (fast/slow).
//  Sits between ControlUnit (play/pause state, remote buttons), the flash byte
//  reader and the audio interface.
// PARAMETERS
//  ADDR_W       23         flash byte-address width
//  SONG0_START  23'h000000 first byte of song 0
//  SONG0_END    23'h1FFFFF last byte of song 0 (odd; the sample pair ends here)
//  SONG1_START  23'h200000 first byte of song 1
//  SONG1_END    23'h3FFFFF last byte of song 1 (odd)
// PORTS
//  CLOCK        in   1       system clock
//  Reset_N      in   1       synchronous, active-low reset
//  play         in   1       level, 1 = playing, 0 = paused
//  sample_req   in   1       1-cycle pulse from audio interface (data_over)
//  next_song    in   1       1-cycle pulse
//  prev_song    in   1       1-cycle pulse
//  restart      in   1       1-cycle pulse
//  fast         in   1       level, 2x rate
//  slow         in   1       level, 0.5x rate
//  rd_req       out  1       flash byte-read request
//  rd_addr      out  ADDR_W  flash byte address
//  rd_ack       in   1       read done, rd_data valid this cycle
//  rd_data      in   8       flash byte
//  musicData    out  16      current sample, {hi,lo}
//  sample_valid out  1       1-cycle pulse when musicData updates
//  SecondSong   out  1       0 = song 0, 1 = song 1
//  underrun     out  1       sticky; a sample_req was dropped
// BEHAVIOUR
//  Reset (Reset_N = 0 at a clock edge):
//   - State goes to IDLE and the address goes to SONG0_START.
//   - rd_req, sample_valid, SecondSong and underrun go to 0; musicData goes to 0.
//   - If a fetch is in progress, rd_req is low the cycle after the reset edge.
//  States:
//   - IDLE -> WAIT once Reset_N = 1.
//   - WAIT -> RD_LO on sample_req with play = 1 and a fetch needed.
//   - RD_LO -> RD_HI on rd_ack (latch lo byte).
//   - RD_HI -> OUT on rd_ack (latch hi byte).
//   - OUT -> WAIT.
//  Handshake: rd_req is registered. rd_req and rd_addr stay stable until
//   rd_ack. rd_req is low for at least 1 cycle between the lo and hi reads.
//  Fetch: lo byte at addr, hi byte at addr+1. In OUT: musicData = {hi,lo},
//   sample_valid = 1 for 1 cycle (1 cycle after the hi rd_ack), then advance addr.
//  Rate:
//   - Normal: addr += 2.
//   - fast only: addr += 4.
//   - slow only: each sample is output twice. An internal repeat toggle makes
//     every second sample_req re-pulse sample_valid the next cycle with
//     unchanged musicData and no fetch; the toggle clears on any song change.
//   - fast and slow both set: normal rate.
//  End of song: if the advanced addr > current SONG*_END, apply the
//   end-of-song rule (see CONFIGURATION). The addr compare uses ADDR_W+1 bits,
//   so no wrap-around is possible.
//  Pause: when play = 0, sample_req is ignored and musicData is forced to
//   16'h0000 (silence). A fetch already in progress completes, but its result
//   is not shown until play = 1. Addr is kept, so resume continues in place.
//  Song commands:
//   - Priority: next > prev > restart, when pulses coincide.
//   - next: toggles SecondSong (wraps from song 1 to song 0).
//   - prev: toggles SecondSong the same way (2 songs).
//   - restart: keeps SecondSong.
//   - In all three cases addr is set to the start of the selected song.
//   - Applied in WAIT in the cycle after the pulse. A pulse that arrives
//     mid-fetch is latched and applied on return to WAIT; the fetched sample
//     is still output.
//  Overrun: sample_req in any state other than WAIT (play = 1) is dropped and
//   sets underrun. underrun is cleared only by reset.
// CONFIGURATION
//  SEQ_LOOP_EN defined: at end of song, addr = start of the same song, and
//   SecondSong is unchanged (repeat-one).
//  SEQ_LOOP_EN undefined: at end of song, advance to the other song, set addr
//   to its start and toggle SecondSong (continuous playlist).
// TESTING
//  - Reset: Reset_N = 0 for 2 cycles mid RD_HI -> rd_req = 0, musicData = 0,
//    and the first read after release is at 23'h000000.
//  - Normal fetch: flash bytes 34,12 at addr 0,1 with rd_ack latency 3 ->
//    musicData = 16'h1234 and sample_valid 1 cycle after the 2nd ack; next
//    rd_addr = 2.
//  - Fast / slow: fast = 1 -> read addrs 0,1,4,5,8,9. slow = 1 with 4
//    sample_reqs -> only 2 fetches and 4 sample_valid pulses (A,A,B,B).
//  - End of song: with SONG0_END = 23'h000007, the 5th sample -> with
//    SEQ_LOOP_EN, read addr 0; without it, read addr SONG1_START and
//    SecondSong = 1.
//  - Songs: next_song and prev_song in the same cycle -> SecondSong = 1 and
//    addr = SONG1_START. restart during RD_LO -> the current sample is output,
//    then the read is at the current song's start.
//  - Pause: play = 0 with sample_req pulses -> no rd_req, musicData = 0.
//    sample_req during RD_LO -> underrun = 1, held until reset.

Source files
------------

// File: rtl/playback_sequencer.sv
// Flash-read sequencer for audio playback: turns codec sample requests into two-byte
// flash fetches, with song selection and rate control. Optional SEQ_LOOP_EN: repeat-one at end of song.
module playback_sequencer #(
  parameter int unsigned       ADDR_W      = 23,
  parameter logic [ADDR_W-1:0] SONG0_START = 23'h000000,
  parameter logic [ADDR_W-1:0] SONG0_END   = 23'h1FFFFF,
  parameter logic [ADDR_W-1:0] SONG1_START = 23'h200000,
  parameter logic [ADDR_W-1:0] SONG1_END   = 23'h3FFFFF
) (
  input  logic              CLOCK,
  input  logic              Reset_N,
  input  logic              play,
  input  logic              sample_req,
  input  logic              next_song,
  input  logic              prev_song,
  input  logic              restart,
  input  logic              fast,
  input  logic              slow,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [7:0]        rd_data,
  output logic [15:0]       musicData,
  output logic              sample_valid,
  output logic              SecondSong,
  output logic              underrun
);

  typedef enum logic [2:0] {IDLE, WAIT, RD_LO, RD_HI, OUT} state_t;
  // Ordered so that a numerically larger command has higher priority
  typedef enum logic [1:0] {CMD_NONE, CMD_RESTART, CMD_PREV, CMD_NEXT} cmd_t;

  state_t            state_q, state_d;
  cmd_t              cmd_q, cmd_d, in_cmd;
  logic [ADDR_W-1:0] addr_q, addr_d, rd_addr_q, rd_addr_d, base_addr;
  logic              rd_req_q, rd_req_d, valid_q, valid_d;
  logic              song_q, song_d, base_song, underrun_q, underrun_d;
  logic              rep_q, rep_d, rep_eff;
  logic [7:0]        lo_q, lo_d;
  logic [15:0]       sample_q, sample_d;
  logic [ADDR_W:0]   step, adv, end_cur;
  logic              slow_only, fast_only;

  assign slow_only = slow & ~fast;
  assign fast_only = fast & ~slow;

  always_comb begin
    in_cmd = CMD_NONE;
    if (next_song)      in_cmd = CMD_NEXT;
    else if (prev_song) in_cmd = CMD_PREV;
    else if (restart)   in_cmd = CMD_RESTART;
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = (in_cmd > cmd_q) ? in_cmd : cmd_q;
    addr_d     = addr_q;
    rd_addr_d  = rd_addr_q;
    rd_req_d   = rd_req_q;
    valid_d    = 1'b0;
    song_d     = song_q;
    underrun_d = underrun_q;
    rep_d      = rep_q;
    lo_d       = lo_q;
    sample_d   = sample_q;
    base_song  = song_q;
    base_addr  = addr_q;
    rep_eff    = rep_q;
    step       = fast_only ? (ADDR_W+1)'(4) : (ADDR_W+1)'(2);
    adv        = {1'b0, addr_q} + step;
    end_cur    = {1'b0, song_q ? SONG1_END : SONG0_END};

    if (sample_req && play && state_q != WAIT) underrun_d = 1'b1;

    case (state_q)
      IDLE: state_d = WAIT;
      WAIT: begin
        // A latched song command takes effect now; a request in the same cycle fetches from the new start
        if (cmd_q != CMD_NONE) begin
          if (cmd_q != CMD_RESTART) base_song = ~song_q;
          base_addr = base_song ? SONG1_START : SONG0_START;
          rep_eff   = 1'b0;
          song_d    = base_song;
          addr_d    = base_addr;
          rep_d     = 1'b0;
          cmd_d     = in_cmd;
        end
        if (sample_req && play) begin
          if (slow_only && rep_eff) begin
            valid_d = 1'b1;
            rep_d   = 1'b0;
          end else begin
            state_d   = RD_LO;
            rd_req_d  = 1'b1;
            rd_addr_d = base_addr;
          end
        end
      end
      RD_LO: begin
        if (rd_req_q && rd_ack) begin
          lo_d     = rd_data;
          rd_req_d = 1'b0;
          state_d  = RD_HI;
        end
      end
      RD_HI: begin
        // First cycle here keeps rd_req low, giving the gap between the two byte reads
        if (!rd_req_q) begin
          rd_req_d  = 1'b1;
          rd_addr_d = addr_q + ADDR_W'(1);
        end else if (rd_ack) begin
          sample_d = {rd_data, lo_q};
          valid_d  = 1'b1;
          rd_req_d = 1'b0;
          state_d  = OUT;
        end
      end
      OUT: begin
        state_d = WAIT;
        rep_d   = slow_only;
        if (adv > end_cur) begin
`ifdef SEQ_LOOP_EN
          addr_d = song_q ? SONG1_START : SONG0_START;
`else
          song_d = ~song_q;
          addr_d = song_q ? SONG0_START : SONG1_START;
          rep_d  = 1'b0;
`endif
        end else begin
          addr_d = adv[ADDR_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!Reset_N) begin
      state_q    <= IDLE;
      cmd_q      <= CMD_NONE;
      addr_q     <= SONG0_START;
      rd_addr_q  <= SONG0_START;
      rd_req_q   <= 1'b0;
      valid_q    <= 1'b0;
      song_q     <= 1'b0;
      underrun_q <= 1'b0;
      rep_q      <= 1'b0;
      lo_q       <= '0;
      sample_q   <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      rd_addr_q  <= rd_addr_d;
      rd_req_q   <= rd_req_d;
      valid_q    <= valid_d;
      song_q     <= song_d;
      underrun_q <= underrun_d;
      rep_q      <= rep_d;
      lo_q       <= lo_d;
      sample_q   <= sample_d;
    end
  end

  assign rd_req       = rd_req_q;
  assign rd_addr      = rd_addr_q;
  assign musicData    = play ? sample_q : '0;
  assign sample_valid = valid_q & play;
  assign SecondSong   = song_q;
  assign underrun     = underrun_q;

endmodule
